mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for RV32I byte/half/word accesses on a single-port memory with registered reads.
// Optional upper-address range check: define MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_unit #(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t           state, state_nxt;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q, wdata_q, merge_q;
    logic             f3_ok, align_err, range_err, req_err;
    logic [WIDTH-1:0] load_ext;

    // Width/sign decode shares bits: [1:0] picks B/H/W, [2] selects zero-extension.
    always_comb begin
        if (req_we)
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    localparam int ADDR_BITS = $clog2(MEM_SIZE);
    assign range_err = (req_addr >> ADDR_BITS) != '0;
`else
    assign range_err = 1'b0;
`endif

    assign req_err = !f3_ok || align_err || range_err;

    // The memory returns the addressed byte in lane 0, so extraction never shifts.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{mem_rdata[7] & ~f3_q[2]}}, mem_rdata[7:0]};
            2'b01:   load_ext = {{16{mem_rdata[15] & ~f3_q[2]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                              state_nxt = RESP;
                    else if (req_we && req_funct3 == 3'b010)  state_nxt = WRITE;
                    else                                      state_nxt = READ;
                end
            end
            READ: begin
                mem_ren   = 1'b1;
                mem_addr  = addr_q;
                state_nxt = WAIT;
            end
            WAIT:  state_nxt = we_q ? WRITE : RESP;
            WRITE: begin
                mem_wen   = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = (f3_q == 3'b010) ? wdata_q : merge_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response registers change only on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    if (req_err) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (we_q) begin
                        merge_q <= f3_q[0] ? {mem_rdata[31:16], wdata_q[15:0]}
                                           : {mem_rdata[31:8], wdata_q[7:0]};
                    end else begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory model (lane 0 = addressed byte).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    mem_access_unit #(.WIDTH(32), .MEM_SIZE(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];

    // Upper address bits alias, as in the attached memory.
    always @(posedge clk) begin
        if (mem_ren)
            mem_rdata <= {mem[12'(mem_addr + 32'd3)], mem[12'(mem_addr + 32'd2)],
                          mem[12'(mem_addr + 32'd1)], mem[12'(mem_addr)]};
        if (mem_wen)
            for (int i = 0; i < 4; i++) mem[12'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          ren_c, wen_c, resp_c;
    logic [31:0] ren_addr, wen_data, rd;
    logic        er;
    logic        both = 1'b0;

    // Issue one request; cycle numbers count from the acceptance edge.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] wd, input bit hold, input bit sync);
        if (sync) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = ad; req_wdata = wd;
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        ren_c = -1; wen_c = -1; resp_c = -1;
        ren_addr = 'x; wen_data = 'x; rd = 'x; er = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!hold) begin
                req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
                req_addr = ~ad; req_wdata = ~wd;
            end
            if (mem_ren && mem_wen) both = 1'b1;
            if (mem_ren && ren_c < 0) begin ren_c = c; ren_addr = mem_addr; end
            if (mem_wen && wen_c < 0) begin wen_c = c; wen_data = mem_wdata; end
            if (resp_valid) begin resp_c = c; rd = resp_rdata; er = resp_err; break; end
        end
    endtask

    task automatic res(input string t, input int e_ren, input int e_wen, input int e_resp,
                       input logic [31:0] e_rd, input logic e_er);
        chk({t, ".ren_cycle"},  32'(ren_c),  32'(e_ren));
        chk({t, ".wen_cycle"},  32'(wen_c),  32'(e_wen));
        chk({t, ".resp_cycle"}, 32'(resp_c), 32'(e_resp));
        chk({t, ".rdata"}, rd, e_rd);
        chk({t, ".err"},   32'(er), 32'(e_er));
    endtask

    int seen;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'h8899AABB;
        {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]} = 32'hCAFEF00D;
        {mem[12'h003], mem[12'h002], mem[12'h001], mem[12'h000]} = 32'h11223344;

        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.ren_wen", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.rdata_err", resp_rdata | 32'(resp_err), 32'd0);
        rst = 1'b0;

        run(1'b0, 3'b000, 32'h100, 32'h0, 0, 1);      // LB
        res("lb_100", 1, -1, 3, 32'hFFFFFFBB, 1'b0);
        chk("lb_100.mem_addr", ren_addr, 32'h100);
        @(negedge clk);
        chk("hold.rdata", resp_rdata, 32'hFFFFFFBB);
        chk("hold.resp_valid", 32'(resp_valid), 32'd0);

        run(1'b0, 3'b101, 32'h100, 32'h0, 0, 0);      // LHU
        res("lhu_100", 1, -1, 3, 32'h0000AABB, 1'b0);
        run(1'b0, 3'b001, 32'h101, 32'h0, 0, 1);      // LH misaligned
        res("lh_101", -1, -1, 1, 32'h0, 1'b1);

        run(1'b1, 3'b000, 32'h100, 32'h12345678, 0, 1);  // SB
        res("sb_100", 1, 3, 4, 32'h0, 1'b0);
        chk("sb_100.wdata", wen_data, 32'h8899AA78);
        run(1'b0, 3'b010, 32'h100, 32'h0, 0, 1);
        res("lw_100", 1, -1, 3, 32'h8899AA78, 1'b0);
        run(1'b0, 3'b001, 32'h100, 32'h0, 0, 1);
        res("lh_100", 1, -1, 3, 32'hFFFFAA78, 1'b0);
        run(1'b0, 3'b100, 32'h103, 32'h0, 0, 1);
        res("lbu_103", 1, -1, 3, 32'h00000088, 1'b0);
        run(1'b0, 3'b010, 32'h102, 32'h0, 0, 1);
        res("lw_102", -1, -1, 1, 32'h0, 1'b1);
        run(1'b0, 3'b011, 32'h100, 32'h0, 0, 1);
        res("load_f3_011", -1, -1, 1, 32'h0, 1'b1);
        run(1'b1, 3'b100, 32'h100, 32'h0, 0, 1);
        res("store_f3_100", -1, -1, 1, 32'h0, 1'b1);

        run(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 1, 1);  // SW, valid held
        res("sw_200", -1, 1, 2, 32'h0, 1'b0);
        chk("sw_200.wdata", wen_data, 32'hDEADBEEF);
        chk("sw_200.ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        run(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 0, 0);
        res("sw_200_b2b", -1, 1, 2, 32'h0, 1'b0);
        run(1'b0, 3'b010, 32'h200, 32'h0, 0, 1);
        res("lw_200", 1, -1, 3, 32'hDEADBEEF, 1'b0);

        // SH aborted by reset during WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h300; req_wdata = 32'h5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sh_rst.ren_read", 32'(mem_ren), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("sh_rst.ready", 32'(req_ready), 32'd1);
        chk("sh_rst.ren_wen", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("sh_rst.mem_addr", mem_addr, 32'd0);
        chk("sh_rst.mem_wdata", mem_wdata, 32'd0);
        chk("sh_rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("sh_rst.rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || mem_wen) seen++;
        end
        chk("sh_rst.no_resp_no_write", 32'(seen), 32'd0);
        run(1'b0, 3'b010, 32'h300, 32'h0, 0, 1);
        res("lw_300", 1, -1, 3, 32'hCAFEF00D, 1'b0);

        run(1'b0, 3'b010, 32'h1000, 32'h0, 0, 1);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        res("lw_1000", -1, -1, 1, 32'h0, 1'b1);
`else
        res("lw_1000", 1, -1, 3, 32'h11223344, 1'b0);
        chk("lw_1000.mem_addr", ren_addr, 32'h1000);
`endif
        chk("no_ren_wen_overlap", 32'(both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
